user_clk_div_switch: RTL and testbench
======================================

// Module: user_clk_div_switch
// PURPOSE
//   Single-domain, parametrised successor to the plain clock select: NUM_SRC divided-clock sources derived from aclk,
//   one selected at a time, switched glitch-free (period completes, then a low dead gap). Drives registered clk_out
//   (fabric clock-like signal) and clk_en (one-cycle enable at each clk_out rising edge) to downstream logic.
// PARAMETERS
//   NUM_SRC    4  number of divided sources, >=2
//   DIV_W      8  width of each divide ratio
//   GAP_CYCLES 2  forced low aclk cycles between old and new source, 0 allowed
//   RESET_SEL  0  source active after reset, < NUM_SRC
//   SEL_W      localparam = max(1,$clog2(NUM_SRC))
// PORTS
//   aclk         in   1              sole clock, all logic rising-edge
//   aresetn      in   1              asynchronous, active-low reset
//   div_ratio    in   NUM_SRC*DIV_W  ratio of source i in bits [i*DIV_W +: DIV_W]
//   sel_in       in   SEL_W          requested source
//   sel_valid    in   1              request strobe
//   sel_ready    out  1              request accepted when sel_valid&&sel_ready
//   sel_err      out  1              one-cycle pulse: accepted sel_in >= NUM_SRC
//   active_sel   out  SEL_W          source currently driving outputs
//   switching    out  1              high in DRAIN and GAP
//   clk_out      out  1              divided clock, registered
//   clk_en       out  1              one-cycle pulse coincident with clk_out rising
// BEHAVIOUR
//   Reset (async assert, sync release): state=RUN, cnt=0, active_sel=RESET_SEL, clk_out=clk_en=sel_err=switching=0,
//     sel_ready=1. First period starts at first aclk edge after release (clk_en=1 on that cycle's registered output).
//   Period: ratio r latched from active channel at each cnt==0 reload; mid-period div_ratio changes apply next period.
//     cnt runs 0..r-1 and wraps; clk_en=(cnt==0); clk_out=(cnt < r>>1). r=3 -> 1 high, 2 low.
//     r<2 -> source disabled: clk_out=clk_en=0, cnt held 0, ratio re-sampled every cycle.
//   sel_ready=1 only in RUN. Accepted request:
//     sel_in>=NUM_SRC -> sel_err pulse next cycle, no state change.
//     sel_in==active_sel -> no effect, stay RUN, no gap.
//     otherwise -> latch target, go DRAIN.
//   FSM:
//     RUN   -> DRAIN on accepted valid switch.
//     DRAIN: current source continues unchanged; on cycle with cnt==r-1 (or immediately if r<2) -> GAP,
//            active_sel<=target on that transition; if GAP_CYCLES==0 go straight to RUN.
//     GAP:   clk_out=clk_en=0 for exactly GAP_CYCLES cycles, then RUN with cnt=0 (clk_en=1 that cycle).
//   Guarantee: clk_out never shows a high or low phase shorter than min(old,new) source phase; no runt pulses.
//   sel_valid ignored outside RUN (no queuing). Reset mid-DRAIN/GAP aborts switch, returns to reset values.
// CONFIGURATION
//   USER_CLK_SWITCH_COUNT_EN defined: adds port switch_count out 16 = completed switches (incremented on DRAIN->GAP/RUN
//     transition), wraps 0xFFFF->0, reset 0. Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   NUM_SRC=4, ratios{2,3,4,8}, GAP=2, RESET_SEL=0: release reset -> clk_out 1,0,1,0...; clk_en every 2nd cycle.
//   In RUN on src1 (r=3) at cnt=1, request sel_in=3 -> DRAIN to cnt=2, then 2 low gap cycles, then 4 high/4 low,
//     active_sel=3 at gap entry, sel_ready=0 and switching=1 throughout DRAIN+GAP.
//   Request sel_in==active_sel -> sel_ready stays 1, switching stays 0, clk_out period undisturbed.
//   NUM_SRC=3, request sel_in=3 -> sel_err=1 for one cycle, active_sel and clk_out unchanged.
//   Change active div_ratio 4->6 at cnt=1 -> current period stays 4 cycles, next period 3 high/3 low.
//   Assert aresetn low mid-GAP -> all outputs to reset values immediately; after release active_sel=RESET_SEL;
//     with USER_CLK_SWITCH_COUNT_EN, switch_count=0 and counts 1 after one completed switch.

Source files
------------

// File: rtl/user_clk_div_switch.sv
// Glitch-free selector over NUM_SRC aclk dividers; clk_out/clk_en registered, one aclk behind the phase counter.
// sel_ready drops for the whole drain+gap; switch_count port exists only with USER_CLK_SWITCH_COUNT_EN defined.
module user_clk_div_switch #(
  parameter int NUM_SRC    = 4,
  parameter int DIV_W      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RESET_SEL  = 0,
  localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_SRC*DIV_W-1:0] div_ratio,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  output logic                     sel_err,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switching,
`ifdef USER_CLK_SWITCH_COUNT_EN
  output logic [15:0]              switch_count,
`endif
  output logic                     clk_out,
  output logic                     clk_en
);

  typedef enum logic [1:0] {RUN, DRAIN, GAP} state_t;

  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [SEL_W-1:0] RESET_SEL_V = SEL_W'(RESET_SEL);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             sel_err_q, sel_err_d;

  logic [DIV_W-1:0] ratio_arr [NUM_SRC];
  logic [DIV_W-1:0] r_eff;
  logic             src_on;
  logic             period_last;
  logic             req_acc;
  logic             req_bad;
  logic             drain_done;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ratio
    assign ratio_arr[i] = div_ratio[i*DIV_W +: DIV_W];
  end

  // The ratio is only sampled at a period boundary; mid-period changes wait for the next one.
  assign r_eff       = (cnt_q == '0) ? ratio_arr[active_q] : ratio_q;
  assign src_on      = (r_eff >= DIV_W'(2));
  assign period_last = src_on && (cnt_q == r_eff - DIV_W'(1));
  assign req_acc     = sel_valid && (state_q == RUN);
  assign req_bad     = (32'(sel_in) >= 32'(NUM_SRC));
  assign drain_done  = (state_q == DRAIN) && (!src_on || period_last);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ratio_d   = ratio_q;
    active_d  = active_q;
    target_d  = target_q;
    gap_d     = gap_q;
    clk_out_d = 1'b0;
    clk_en_d  = 1'b0;
    sel_err_d = 1'b0;

    if (state_q != GAP) begin
      ratio_d = r_eff;
      if (src_on) begin
        clk_en_d  = (cnt_q == '0);
        clk_out_d = (cnt_q < (r_eff >> 1));
        cnt_d     = period_last ? '0 : cnt_q + DIV_W'(1);
      end else begin
        cnt_d = '0;
      end
    end

    case (state_q)
      RUN: begin
        if (req_acc) begin
          if (req_bad) begin
            sel_err_d = 1'b1;
          end else if (sel_in != active_q) begin
            target_d = sel_in;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Old source finishes its low phase before the new one is attached.
        if (drain_done) begin
          active_d = target_q;
          cnt_d    = '0;
          gap_d    = '0;
          state_d  = (GAP_CYCLES == 0) ? RUN : GAP;
        end
      end
      GAP: begin
        cnt_d = '0;
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ratio_q   <= '0;
      active_q  <= RESET_SEL_V;
      target_q  <= RESET_SEL_V;
      gap_q     <= '0;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      active_q  <= active_d;
      target_q  <= target_d;
      gap_q     <= gap_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
      sel_err_q <= sel_err_d;
    end
  end

`ifdef USER_CLK_SWITCH_COUNT_EN
  logic [15:0] sw_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sw_cnt_q <= '0;
    end else if (drain_done) begin
      sw_cnt_q <= sw_cnt_q + 16'd1;
    end
  end

  assign switch_count = sw_cnt_q;
`endif

  assign sel_ready  = (state_q == RUN);
  assign switching  = (state_q != RUN);
  assign active_sel = active_q;
  assign sel_err    = sel_err_q;
  assign clk_out    = clk_out_q;
  assign clk_en     = clk_en_q;

endmodule

// File: tb/tb_user_clk_div_switch.sv
// Bench for user_clk_div_switch: waveform-queue model checked every cycle, plus directed literal sequences.
module tb_user_clk_div_switch;

  localparam int GAP = 2;

  logic        aclk;
  logic        aresetn;
  logic [31:0] div_ratio;
  logic [1:0]  sel_in;
  logic        sel_valid;
  logic        sel_ready, sel_err, switching, clk_out, clk_en;
  logic [1:0]  active_sel;

  logic [23:0] div_ratio3;
  logic [1:0]  sel_in3;
  logic        sel_valid3;
  logic        sel_ready3, sel_err3, switching3, clk_out3, clk_en3;
  logic [1:0]  active_sel3;

`ifdef USER_CLK_SWITCH_COUNT_EN
  logic [15:0] switch_count, switch_count3;
`endif

  int checks   = 0;
  int failures = 0;

  user_clk_div_switch #(.NUM_SRC(4), .DIV_W(8), .GAP_CYCLES(GAP), .RESET_SEL(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .div_ratio(div_ratio), .sel_in(sel_in),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
    .active_sel(active_sel), .switching(switching),
`ifdef USER_CLK_SWITCH_COUNT_EN
    .switch_count(switch_count),
`endif
    .clk_out(clk_out), .clk_en(clk_en)
  );

  user_clk_div_switch #(.NUM_SRC(3), .DIV_W(8), .GAP_CYCLES(GAP), .RESET_SEL(0)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .div_ratio(div_ratio3), .sel_in(sel_in3),
    .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_err(sel_err3),
    .active_sel(active_sel3), .switching(switching3),
`ifdef USER_CLK_SWITCH_COUNT_EN
    .switch_count(switch_count3),
`endif
    .clk_out(clk_out3), .clk_en(clk_en3)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: output waveform as a queue of {clk_out,clk_en}; a whole period is queued when the queue runs dry.
  logic [1:0] mq[$];
  int         m_active, m_target, m_gap_left, m_count;
  bit         m_pending;
  bit         e_out, e_en, e_err;

  always @(posedge aclk or negedge aresetn) begin
    bit         ready_prev;
    int         r;
    logic [1:0] ent;
    if (!aresetn) begin
      mq.delete();
      m_active = 0; m_target = 0; m_pending = 0; m_gap_left = 0; m_count = 0;
      e_out = 0; e_en = 0; e_err = 0;
    end else begin
      ready_prev = !m_pending && (m_gap_left == 0);
      if (mq.size() == 0) begin
        r = int'(div_ratio[m_active*8 +: 8]);
        if (r < 2) mq.push_back(2'b00);
        else for (int c = 0; c < r; c++) mq.push_back({c < r / 2, c == 0});
      end
      ent = mq.pop_front();
      if (m_gap_left > 0) m_gap_left--;
      e_out = ent[1];
      e_en  = ent[0];
      e_err = 0;
      if (mq.size() == 0 && m_pending) begin
        m_active  = m_target;
        m_pending = 0;
        m_count   = (m_count + 1) % 65536;
        for (int g = 0; g < GAP; g++) mq.push_back(2'b00);
        m_gap_left = GAP;
      end
      if (sel_valid && ready_prev) begin
        if (int'(sel_in) >= 4) e_err = 1;
        else if (int'(sel_in) != m_active) begin
          m_target  = int'(sel_in);
          m_pending = 1;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      check("m_clk_out", 32'(clk_out), 32'(e_out));
      check("m_clk_en", 32'(clk_en), 32'(e_en));
      check("m_sel_err", 32'(sel_err), 32'(e_err));
      check("m_active", 32'(active_sel), 32'(m_active));
      check("m_switching", 32'(switching), 32'(m_pending || m_gap_left > 0));
      check("m_sel_ready", 32'(sel_ready), 32'(!m_pending && m_gap_left == 0));
`ifdef USER_CLK_SWITCH_COUNT_EN
      check("m_switch_count", 32'(switch_count), 32'(m_count));
`endif
    end
  end

  int exp_a_out[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_a_en [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int exp_a_sw [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int exp_a_act[12] = '{1, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
  int exp_b_out[9]  = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
  int exp_b_en [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (switching !== 1'b0 && n < 200) begin tick(); n++; end
    check({name, "_idle"}, 32'(switching), 32'd0);
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (clk_en !== 1'b1 && n < 200) begin tick(); n++; end
    check({name, "_en"}, 32'(clk_en), 32'd1);
  endtask

  task automatic request(input logic [1:0] s);
    sel_valid = 1'b1;
    sel_in    = s;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_clk_out"}, 32'(clk_out), 32'd0);
    check({name, "_clk_en"}, 32'(clk_en), 32'd0);
    check({name, "_sel_ready"}, 32'(sel_ready), 32'd1);
    check({name, "_switching"}, 32'(switching), 32'd0);
    check({name, "_active"}, 32'(active_sel), 32'd0);
    check({name, "_sel_err"}, 32'(sel_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    aresetn    = 1'b0;
    sel_valid  = 1'b0;
    sel_in     = 2'd0;
    div_ratio  = {8'd8, 8'd4, 8'd3, 8'd2};
    sel_valid3 = 1'b0;
    sel_in3    = 2'd0;
    div_ratio3 = {8'd2, 8'd2, 8'd2};
    repeat (3) tick();
    check_reset_vals("reset");
    aresetn = 1'b1;

    // Boot on src0 (r=2); the 3-source instance gets an out-of-range request.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("boot_clk_out", 32'(clk_out), 32'(k % 2 == 0));
      check("boot_clk_en", 32'(clk_en), 32'(k % 2 == 0));
      check("s3_sel_err", 32'(sel_err3), 32'(k == 1));
      check("s3_clk_out", 32'(clk_out3), 32'(k % 2 == 0));
      check("s3_active", 32'(active_sel3), 32'd0);
      check("s3_switching", 32'(switching3), 32'd0);
      check("s3_sel_ready", 32'(sel_ready3), 32'd1);
      sel_valid3 = (k == 0);
      sel_in3    = 2'd3;
    end

    request(2'd1);
    wait_idle("to_src1");
    wait_en("sync_src1");
    sel_valid = 1'b1;
    sel_in    = 2'd3;
    for (int k = 0; k < 12; k++) begin
      tick();
      sel_valid = 1'b0;
      check("sw13_clk_out", 32'(clk_out), 32'(exp_a_out[k]));
      check("sw13_clk_en", 32'(clk_en), 32'(exp_a_en[k]));
      check("sw13_switching", 32'(switching), 32'(exp_a_sw[k]));
      check("sw13_sel_ready", 32'(sel_ready), 32'(1 - exp_a_sw[k]));
      check("sw13_active", 32'(active_sel), 32'(exp_a_act[k]));
    end

    sel_valid = 1'b1;
    sel_in    = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("same_sel_ready", 32'(sel_ready), 32'd1);
      check("same_switching", 32'(switching), 32'd0);
    end
    sel_valid = 1'b0;

    request(2'd2);
    wait_idle("to_src2");
    wait_en("sync_src2");
    div_ratio[2*8 +: 8] = 8'd6;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("ratio_clk_out", 32'(clk_out), 32'(exp_b_out[k]));
      check("ratio_clk_en", 32'(clk_en), 32'(exp_b_en[k]));
    end

    div_ratio[1*8 +: 8] = 8'd1;
    request(2'd1);
    wait_idle("to_off");
    for (int k = 0; k < 6; k++) begin
      tick();
      check("off_clk_out", 32'(clk_out), 32'd0);
      check("off_clk_en", 32'(clk_en), 32'd0);
      check("off_active", 32'(active_sel), 32'd1);
    end
    request(2'd0);
    tick();
    check("off_drain_active", 32'(active_sel), 32'd0);
    check("off_drain_switching", 32'(switching), 32'd1);
    wait_idle("from_off");
    div_ratio[1*8 +: 8] = 8'd3;
    repeat (3) tick();

    request(2'd3);
    n = 0;
    while (active_sel !== 2'd3 && n < 100) begin tick(); n++; end
    check("gap_active", 32'(active_sel), 32'd3);
    check("gap_switching", 32'(switching), 32'd1);
    aresetn = 1'b0;
    #1;
    check_reset_vals("midgap");
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    check("rel_active", 32'(active_sel), 32'd0);
    check("rel_clk_en", 32'(clk_en), 32'd1);
`ifdef USER_CLK_SWITCH_COUNT_EN
    check("rel_switch_count", 32'(switch_count), 32'd0);
`endif
    request(2'd2);
    wait_idle("after_rst");
`ifdef USER_CLK_SWITCH_COUNT_EN
    check("one_switch_count", 32'(switch_count), 32'd1);
`endif
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
